// File: rtl/serial_frame_sender.sv
// rtl/serial_frame_sender.sv - serialises preamble, 8-bit length and N payload bits MSB first
// Payload bytes arrive over valid/ready into a shift register plus one holding register.
module serial_frame_sender #(
  parameter int                PRE_W    = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       SerOut,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, PRE, LEN, DATA, DONE} state_t;

  state_t           state_q;
  logic [7:0]       len_q, len_sh_q, sh_q, hold_q, idx_q;
  logic [PRE_W-1:0] pre_sh_q;
  logic [8:0]       rem_q;
  logic [5:0]       fetch_q;
  logic [2:0]       bib_q;
  logic             sh_full_q, hold_full_q;
  logic             ser_q, busy_q, done_q, underrun_q;

  logic             take_d;
  logic [8:0]       fetch_init_d;

  assign byte_ready   = busy_q & ~hold_full_q & (fetch_q != 6'd0) & (state_q != DONE);
  assign take_d       = byte_valid & byte_ready;
  assign fetch_init_d = {1'b0, len} + 9'd7;

  assign SerOut   = ser_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      len_sh_q    <= 8'd0;
      sh_q        <= 8'd0;
      hold_q      <= 8'd0;
      idx_q       <= 8'd0;
      pre_sh_q    <= '0;
      rem_q       <= 9'd0;
      fetch_q     <= 6'd0;
      bib_q       <= 3'd0;
      sh_full_q   <= 1'b0;
      hold_full_q <= 1'b0;
      ser_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      // Default byte placement; states that consume a byte on this edge override it.
      if (take_d) begin
        fetch_q <= fetch_q - 6'd1;
        if (!sh_full_q) begin
          sh_q      <= byte_in;
          sh_full_q <= 1'b1;
        end else begin
          hold_q      <= byte_in;
          hold_full_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          ser_q  <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            len_q       <= len;
            fetch_q     <= fetch_init_d[8:3];
            sh_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            ser_q       <= PREAMBLE[PRE_W-1];
            pre_sh_q    <= PREAMBLE << 1;
            idx_q       <= 8'(PRE_W - 1);
            busy_q      <= 1'b1;
            state_q     <= PRE;
          end
        end
        PRE: begin
          if (idx_q != 8'd0) begin
            ser_q    <= pre_sh_q[PRE_W-1];
            pre_sh_q <= pre_sh_q << 1;
            idx_q    <= idx_q - 8'd1;
          end else begin
            ser_q    <= len_q[7];
            len_sh_q <= len_q << 1;
            idx_q    <= 8'd7;
            state_q  <= LEN;
          end
        end
        LEN: begin
          if (idx_q != 8'd0) begin
            ser_q    <= len_sh_q[7];
            len_sh_q <= len_sh_q << 1;
            idx_q    <= idx_q - 8'd1;
          end else if (len_q == 8'd0) begin
            ser_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (sh_full_q || take_d) begin
            // A byte handed over on this very edge goes straight onto the line.
            ser_q     <= sh_full_q ? sh_q[7] : byte_in[7];
            sh_q      <= (sh_full_q ? sh_q : byte_in) << 1;
            sh_full_q <= 1'b1;
            bib_q     <= 3'd7;
            rem_q     <= {1'b0, len_q} - 9'd1;
            state_q   <= DATA;
          end else begin
            ser_q       <= 1'b0;
            underrun_q  <= 1'b1;
            busy_q      <= 1'b0;
            sh_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DATA: begin
          if (rem_q == 9'd0) begin
            ser_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (bib_q != 3'd0) begin
            ser_q <= sh_q[7];
            sh_q  <= sh_q << 1;
            bib_q <= bib_q - 3'd1;
            rem_q <= rem_q - 9'd1;
          end else if (hold_full_q || take_d) begin
            ser_q       <= hold_full_q ? hold_q[7] : byte_in[7];
            sh_q        <= (hold_full_q ? hold_q : byte_in) << 1;
            hold_full_q <= 1'b0;
            bib_q       <= 3'd7;
            rem_q       <= rem_q - 9'd1;
          end else begin
            ser_q       <= 1'b0;
            underrun_q  <= 1'b1;
            busy_q      <= 1'b0;
            sh_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DONE: begin
          ser_q       <= 1'b0;
          busy_q      <= 1'b0;
          sh_full_q   <= 1'b0;
          hold_full_q <= 1'b0;
          fetch_q     <= 6'd0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_sender.sv
// tb/tb_serial_frame_sender.sv - directed frames with hand-computed line patterns
module tb_serial_frame_sender;

  logic       clk = 1'b0;
  logic       rst, start, byte_valid;
  logic [7:0] len, byte_in;
  logic       byte_ready, SerOut, busy, done, underrun;

  serial_frame_sender dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .SerOut(SerOut), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] line;
  int          nbits, busy_cnt, hs, ready_cnt;
  logic        saw_done, saw_under, finished;

  task automatic run_frame(input logic [7:0] n, input logic [7:0] b0, input logic [7:0] b1,
                           input int ngive, input bit poke);
    logic [7:0] bytes [2];
    int  bi;
    bit  take;
    bytes[0] = b0; bytes[1] = b1;
    line = '0; nbits = 0; busy_cnt = 0; hs = 0; ready_cnt = 0;
    saw_done = 0; saw_under = 0; finished = 0; bi = 0;
    @(negedge clk);
    start = 1'b1; len = n;
    @(posedge clk); #1;
    start = 1'b0; len = 8'd0;
    byte_valid = (ngive > 0); byte_in = bytes[0];
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      take = byte_valid && byte_ready;
      if (byte_ready) ready_cnt++;
      if (busy) busy_cnt++;
      if (take) hs++;
      if (done) saw_done = 1;
      if (underrun) saw_under = 1;
      if (done || underrun) begin
        finished = 1;
        break;
      end
      line = {line[62:0], SerOut};
      nbits++;
      @(posedge clk); #1;
      if (take) bi++;
      byte_valid = (bi < ngive);
      byte_in = (bi < 2) ? bytes[bi] : 8'h00;
      if (poke && cyc == 6) begin
        start = 1'b1; len = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  logic quiet;

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_serout", SerOut, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", byte_ready, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    rst = 1'b0;

    // asynchronous reset in the middle of a preamble
    @(negedge clk);
    start = 1'b1; len = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; #1;
    check("mid_rst_serout", SerOut, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", byte_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (SerOut || busy || done) quiet = 1'b0;
    end
    check("post_rst_quiet", quiet, 1'b1);

    run_frame(8'd8, 8'hA5, 8'h00, 1, 0);
    check("full_finished", finished, 1'b1);
    check("full_line", line, 64'(20'b1101_00001000_10100101));
    check("full_nbits", nbits, 20);
    check("full_done", saw_done, 1'b1);
    check("full_underrun", saw_under, 1'b0);
    check("full_busy_cycles", busy_cnt, 21);
    check("full_handshakes", hs, 1);

    run_frame(8'd11, 8'h3C, 8'hE0, 2, 0);
    check("part_finished", finished, 1'b1);
    check("part_line", line, 64'(23'b1101_00001011_00111100111));
    check("part_nbits", nbits, 23);
    check("part_done", saw_done, 1'b1);
    check("part_handshakes", hs, 2);
    check("part_busy_cycles", busy_cnt, 24);

    run_frame(8'd0, 8'h00, 8'h00, 0, 0);
    check("zero_finished", finished, 1'b1);
    check("zero_line", line, 64'(12'b1101_00000000));
    check("zero_nbits", nbits, 12);
    check("zero_done", saw_done, 1'b1);
    check("zero_ready_cycles", ready_cnt, 0);
    check("zero_busy_cycles", busy_cnt, 13);

    run_frame(8'd16, 8'hFF, 8'h00, 1, 0);
    check("under_finished", finished, 1'b1);
    check("under_line", line, 64'(20'b1101_00010000_11111111));
    check("under_nbits", nbits, 20);
    check("under_flag", saw_under, 1'b1);
    check("under_no_done", saw_done, 1'b0);
    check("under_serout", SerOut, 1'b0);
    check("under_busy_cycles", busy_cnt, 20);
    @(negedge clk);
    check("under_idle_busy", busy, 1'b0);
    check("under_idle_done", done, 1'b0);

    run_frame(8'd8, 8'h5A, 8'h00, 1, 1);
    check("poke_finished", finished, 1'b1);
    check("poke_line", line, 64'(20'b1101_00001000_01011010));
    check("poke_nbits", nbits, 20);
    check("poke_done", saw_done, 1'b1);
    check("poke_busy_cycles", busy_cnt, 21);
    @(negedge clk);
    check("poke_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_sender.md
# serial_frame_sender

- Transmit-side counterpart of the serial pass-through receiver.
- Serialises one frame onto `SerOut`, most significant bit first in every field:
  - the start preamble that the receiver's sequence detector matches;
  - an 8-bit payload length N;
  - exactly N payload bits.
- Payload comes in as bytes over a valid/ready handshake and is double-buffered, so the line never stalls mid-frame.
- Sits upstream of the receiver top. Its `SerOut` drives the receiver's `SerIn`.

## Interface
Parameters:
- `PRE_W`, default 4: preamble length in bits.
- `PREAMBLE`, default 4'b1101: preamble pattern, sent from bit PRE_W-1 down to bit 0.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`, input, 1: rising-edge clock.
  - `rst`, input, 1: asynchronous, active-high reset.
- Frame request:
  - `start`, input, 1: request a frame. Sampled only in IDLE.
  - `len`, input, 8: payload length N in bits, 0–255. Captured with `start`.
- Payload byte handshake:
  - `byte_in`, input, 8: payload byte. Bit 7 is sent first.
  - `byte_valid`, input, 1: `byte_in` holds a valid byte.
  - `byte_ready`, output, 1: sender can accept a byte this cycle.
- Line and status:
  - `SerOut`, output, 1: serial line, registered. Idle level is 0.
  - `busy`, output, 1: a frame is in progress.
  - `done`, output, 1: one-cycle pulse at normal frame completion.
  - `underrun`, output, 1: one-cycle pulse when a frame is aborted for lack of payload data.

## Operation
States: IDLE, PRE, LEN, DATA, DONE.

- **IDLE**
  - `SerOut`=0, `busy`=0.
  - `start`=1 captures `len` into `len_r`, loads the bit counter and clears both byte buffers. Next state is PRE.
- **PRE**
  - Drives `PREAMBLE` over PRE_W cycles, then goes to LEN.
- **LEN**
  - Drives `len_r[7]` through `len_r[0]` over 8 cycles.
  - If `len_r`=0, goes to DONE; otherwise goes to DATA.
- **DATA**
  - Drives one payload bit per cycle from the shift register, MSB first.
  - A 9-bit down-counter holds the data bits remaining.
  - A byte counter holds the bytes still to fetch, initialised to ceil(N/8).
  - When the counter reaches 0, goes to DONE.
  - If N mod 8 ≠ 0, only the upper N mod 8 bits of the final byte are sent. Its remaining bits are discarded.
- **DONE**
  - One cycle: `SerOut`=0, `done`=1, `busy`=1.
  - Then returns to IDLE.

Buffering:
- The shift register is loaded directly with the first accepted byte.
- A holding register takes the next byte while the current one is being shifted.
- `byte_ready` = `busy` & (holding register empty) & (bytes-to-fetch > 0) & state≠DONE.
- A transfer happens on a rising edge with `byte_valid` & `byte_ready`.
- The holding register moves into the shift register in the same cycle that the last bit of the current byte leaves.

Boundary conditions:
- **Underrun.** If a new byte is needed on entry to DATA, or on a byte boundary in DATA, and the holding register is empty:
  - the frame aborts: `SerOut`=0 that cycle, `underrun` pulses, next state is IDLE;
  - `done` is not asserted.
- **`start` while busy.** Ignored; `len` is not re-sampled.
- **Excess bytes.** Once bytes-to-fetch is 0, `byte_ready` stays 0, so no excess byte can be accepted.
- **Reset mid-frame.** Immediately forces IDLE. Every output goes to 0 and both buffers are cleared.

## Timing
- Reset values: `SerOut`=0, `busy`=0, `done`=0, `byte_ready`=0, `underrun`=0.
- Let cycle 0 be the rising edge that samples `start`.
- **Line sequence:**
  - cycles 1..PRE_W: `SerOut` = preamble;
  - next 8 cycles: length field;
  - next N cycles: payload;
  - then one DONE cycle.
- **`busy`** rises after cycle 0 and stays high for PRE_W+8+N+1 cycles (13+N cycles at the defaults).
- **First payload byte.** `byte_ready` is high from cycle 1. The first byte must be accepted by the last LEN cycle, which is cycle PRE_W+8, to avoid underrun.
- **Next byte.** Must be accepted before the last bit of the current byte is on the line.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle → all outputs 0 within the same cycle; `SerOut` stays 0 with no `start`.
- **One full byte.** `start` with `len`=8, byte 0xA5 valid from cycle 1 → `SerOut` = 1101, 00001000, 10100101; then `done` pulses; `busy` high for 21 cycles.
- **Partial final byte.** `len`=11, bytes 0x3C then 0xE0 → payload on line is 00111100111; exactly 2 byte handshakes occur.
- **Zero length.** `len`=0 → 1101, 00000000, then `done`; `byte_ready` never asserted.
- **Underrun.** `len`=16, first byte 0xFF, second byte withheld → 8 ones, then `underrun` pulse, `SerOut`=0, back to IDLE with no `done`.
- **`start` while busy.** Assert `start` with `len`=5 mid-frame → ignored; the current frame completes unchanged, with the length field as originally sent.
